delay_sum_beamformer: RTL and testbench
=======================================

// Module: delay_sum_beamformer
// PURPOSE
//   Delay-and-sum stage directly downstream of the 16-channel CIC decimator.
//   Takes one decimated PCM frame (all N_CH mic samples) per in_valid strobe.
//   Stores each channel in its own circular delay line.
//   Sums the per-channel delayed samples, one channel per clk, into a
//   full-precision beam output for the I2S/output stage.
// PARAMETERS
//   N_CH   16  number of mic channels (power of 2)
//   W      16  signed sample width per channel
//   DEPTH  32  delay-line depth in frames (power of 2); max delay DEPTH-1
//   DW     $clog2(DEPTH)  delay/pointer width
//   OW     W+$clog2(N_CH) signed output width (no overflow possible)
// PORTS
//   clk        in   1        system clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        frame strobe from CIC (1 cycle per frame)
//   in_data    in   N_CH*W   packed signed samples; ch k at [k*W +: W]
//   in_ready   out  1        high only in IDLE (and not in rst)
//   dly_we     in   1        delay register write strobe
//   dly_ch     in   $clog2(N_CH)  channel to write
//   dly_val    in   DW       delay in frames for dly_ch
//   out_valid  out  1        1-cycle strobe, beam sample valid
//   out_data   out  OW       signed beam sum, held until next out_valid
//   overrun    out  1        sticky: frame dropped (in_valid while !in_ready)
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, overrun=0, in_ready=0 while rst high.
//     State=IDLE, wr_ptr=0, fill=0, all dly[]=0, acc=0.
//     Delay-line RAM contents are not reset; fill masks them.
//   Accept: cycle T with in_valid && in_ready.
//     Write in_data[k] to line k at wr_ptr; latch rd_base=wr_ptr.
//     wr_ptr <= wr_ptr+1 mod DEPTH; fill <= min(fill+1, DEPTH).
//     Snapshot dly[] into dly_s[]; state -> ACCUM; acc <= 0.
//   FSM: IDLE -> ACCUM (on accept); ACCUM -> DONE (after ch N_CH-1); DONE -> IDLE.
//   ACCUM (cycles T+1..T+N_CH, ch=0..N_CH-1):
//     acc += sext(line[ch][(rd_base - dly_s[ch]) mod DEPTH]).
//     Contribution is 0 if dly_s[ch] >= fill (sample not yet written).
//     fill here is the post-accept value.
//   DONE (cycle T+N_CH+1): out_valid=1, out_data=acc; next cycle IDLE.
//   Latency: out_valid exactly N_CH+1 cycles after accept; in_ready=0 T+1..T+N_CH+1.
//   Delay 0 selects the frame just accepted.
//     Write happens at T and read starts at T+1, so no RAM bypass is needed.
//   dly_we: dly[dly_ch] <= dly_val next edge, any state.
//     Same cycle as accept: the snapshot takes the OLD value.
//     The new value applies from the next frame on.
//   in_valid when !in_ready: frame discarded; no pointer/fill change; overrun <= 1.
//     Cleared only by rst. In-flight computation is unaffected.
//   rst mid-ACCUM/DONE: computation aborted; no out_valid that cycle or after.
//   Pointer wrap: all index arithmetic is modulo DEPTH (DW-bit unsigned).
//   Arithmetic: two's complement; acc is OW bits; never saturates.
// TESTING
//   1 all dly=0, all ch=100, one frame -> out_valid at accept+17, out_data=1600
//   2 all dly=0, all ch=-32768 -> out_data=-524288 (OW=20: 0x80000); all ch=32767 -> 524272
//   3 dly[0]=3, ch0 impulse 1000 in frame 0, others/later frames 0 -> outputs 0,0,0,1000,0
//   4 dly[5]=4, others 0, all ch=1 every frame -> frames 0..3 out 15, frame 4 onward 16 (fill mask)
//   5 dly[0]=31, ch0=k in frame k (k=0..39), others 0 -> frames 0..30 out 0, frame k>=31 out k-31 (wrap)
//   6 in_valid at accept+5 -> dropped, overrun=1, current out unchanged; rst at accept+8 -> no out_valid, out_data=0

Source files
------------

// File: rtl/delay_sum_beamformer_if.sv
// Purpose : bundles the frame, delay-programming and beam-output signals of
//           the delay-and-sum beamformer into one port.
// Ports   : frame in (in_valid/in_data/in_ready), delay write (dly_we/dly_ch/dly_val),
//           beam out (out_valid/out_data) and the sticky overrun flag.
interface delay_sum_beamformer_if #(
  parameter int N_CH  = 16,
  parameter int W     = 16,
  parameter int DEPTH = 32
);
  localparam int DW = $clog2(DEPTH);
  localparam int CW = $clog2(N_CH);
  localparam int OW = W + $clog2(N_CH);

  logic                  in_valid;
  logic [N_CH*W-1:0]     in_data;
  logic                  in_ready;
  logic                  dly_we;
  logic [CW-1:0]         dly_ch;
  logic [DW-1:0]         dly_val;
  logic                  out_valid;
  logic signed [OW-1:0]  out_data;
  logic                  overrun;

  // master: frame/delay source (CIC side or bench); slave: the beamformer
  modport master (
    output in_valid, in_data, dly_we, dly_ch, dly_val,
    input  in_ready, out_valid, out_data, overrun
  );
  modport slave (
    input  in_valid, in_data, dly_we, dly_ch, dly_val,
    output in_ready, out_valid, out_data, overrun
  );
endinterface

// File: rtl/delay_sum_beamformer.sv
// Purpose : delay-and-sum beamformer; each channel has a circular delay line
//           of DEPTH frames, the delayed samples are summed one channel per clk.
// Ports   : clk, rst (sync, active-high), bus (slave modport: frame in,
//           per-channel delay writes, beam out with 1-cycle out_valid, overrun).
// Latency : out_valid exactly N_CH+1 cycles after the accepting cycle; in_ready
//           is low from accept+1 until out_valid has been presented.
module delay_sum_beamformer #(
  parameter int N_CH  = 16,
  parameter int W     = 16,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  delay_sum_beamformer_if.slave  bus
);
  localparam int DW = $clog2(DEPTH);
  localparam int CW = $clog2(N_CH);
  localparam int OW = W + $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q;
  logic [DW-1:0]        wr_ptr;
  logic [DW-1:0]        rd_base;
  logic [DW:0]          fill;          // 0..DEPTH frames written since reset
  logic [DW-1:0]        dly   [N_CH];
  logic [DW-1:0]        dly_s [N_CH];  // delays frozen for the frame in flight
  logic signed [W-1:0]  line  [N_CH][DEPTH];
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] acc_nxt;
  logic signed [OW-1:0] contrib;
  logic signed [OW-1:0] out_data_q;
  logic signed [W-1:0]  sample;
  logic [DW-1:0]        rd_idx;
  logic                 out_valid_q;
  logic                 overrun_q;
  logic                 accept;
  logic                 last_ch;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_ch       = (ch_q == CW'(N_CH - 1));

  // Gate with rst so a reset landing in the DONE cycle still suppresses the strobe.
  assign bus.out_valid = out_valid_q && !rst;
  assign bus.out_data  = out_data_q;
  assign bus.overrun   = overrun_q;

  // Read tap for the channel being summed; DW-bit subtraction wraps the ring.
  // A delay reaching back past the first frame written since reset would hit
  // unwritten RAM, so it contributes zero instead.
  always_comb begin
    rd_idx  = rd_base - dly_s[ch_q];
    sample  = line[ch_q][rd_idx];
    contrib = '0;
    if ({1'b0, dly_s[ch_q]} < fill) begin
      contrib = {{(OW-W){sample[W-1]}}, sample};
    end
    acc_nxt = acc + contrib;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)  state_d = ACCUM;
      ACCUM:   if (last_ch) state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Delay-line storage: not reset, stale contents are masked by fill.
  // The write lands at the accept edge and reads start the cycle after,
  // so a zero delay sees the new frame without any bypass.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_CH; k++) begin
        line[k][wr_ptr] <= bus.in_data[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_base     <= '0;
      fill        <= '0;
      ch_q        <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        dly[k]   <= '0;
        dly_s[k] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;

      // Delay writes are taken in any state; a write coinciding with an
      // accept is not seen by that frame's snapshot (nonblocking order).
      if (bus.dly_we) begin
        dly[bus.dly_ch] <= bus.dly_val;
      end

      if (bus.in_valid && !bus.in_ready) begin
        overrun_q <= 1'b1;
      end

      if (accept) begin
        rd_base <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
        if (fill != (DW+1)'(DEPTH)) begin
          fill <= fill + 1'b1;
        end
        dly_s <= dly;
        acc   <= '0;
        ch_q  <= '0;
      end else if (state_q == ACCUM) begin
        acc  <= acc_nxt;
        ch_q <= ch_q + 1'b1;
        if (last_ch) begin
          out_valid_q <= 1'b1;
          out_data_q  <= acc_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_delay_sum_beamformer.sv
module tb_delay_sum_beamformer;
  localparam int N_CH  = 16;
  localparam int W     = 16;
  localparam int DEPTH = 32;
  localparam int DW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_CH);
  localparam int LAT   = N_CH + 1;

  typedef struct {
    longint data;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_sum_beamformer_if #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH)) bus ();

  delay_sum_beamformer #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: full history of accepted frames plus current delays.
  logic [N_CH*W-1:0] hist[$];
  int                dly_m[N_CH];
  bit                ovr_m;
  exp_t              exp_q[$];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Beam for the newest frame in hist: channel k looks dly_m[k] frames back;
  // a frame older than anything accepted since reset contributes zero.
  function automatic longint beam();
    longint            s = 0;
    int                n = hist.size();
    logic [N_CH*W-1:0] f;
    logic signed [W-1:0] smp;
    for (int k = 0; k < N_CH; k++) begin
      if (dly_m[k] < n) begin
        f   = hist[n-1-dly_m[k]];
        smp = f[k*W +: W];
        s   = s + smp;
      end
    end
    return s;
  endfunction

  function automatic logic [N_CH*W-1:0] all_ch(input int v);
    logic [N_CH*W-1:0] f;
    for (int k = 0; k < N_CH; k++) f[k*W +: W] = W'(v);
    return f;
  endfunction

  // Monitor: pops one expectation per out_valid and checks value and latency.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("latency", cyc - e.cyc, LAT);
      end
    end
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic clear_model();
    exp_q.delete();
    hist.delete();
    for (int k = 0; k < N_CH; k++) dly_m[k] = 0;
    ovr_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.dly_we   = 1'b0;
    clear_model();
    @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [N_CH*W-1:0] f, input bit we = 1'b0,
                            input int wch = 0, input int wval = 0);
    int waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    if (!bus.in_ready) return;
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    bus.dly_we   = we;
    bus.dly_ch   = CW'(wch);
    bus.dly_val  = DW'(wval);
    hist.push_back(f);
    exp_q.push_back('{beam(), cyc});
    if (we) dly_m[wch] = wval;     // same-cycle write applies from the next frame
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dly_we   = 1'b0;
  endtask

  task automatic set_dly(input int ch, input int val);
    bus.dly_we  = 1'b1;
    bus.dly_ch  = CW'(ch);
    bus.dly_val = DW'(val);
    dly_m[ch]   = val;
    @(posedge clk); #1;
    bus.dly_we  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N_CH*W-1:0] f;
    int a;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.dly_we   = 1'b0;
    bus.dly_ch   = '0;
    bus.dly_val  = '0;

    // 1: all channels 100, zero delays
    do_reset();
    send_frame(all_ch(100));
    wait_idle();
    chk("t1_sum", bus.out_data, 1600);

    // 2: full-scale extremes
    do_reset();
    send_frame(all_ch(-32768));
    send_frame(all_ch(32767));
    wait_idle();

    // 3: impulse on ch0 delayed by 3
    do_reset();
    set_dly(0, 3);
    f = '0; f[W-1:0] = W'(1000);
    send_frame(f);
    for (int i = 0; i < 4; i++) send_frame('0);
    wait_idle();
    chk("t3_last", bus.out_data, 0);

    // 4: fill mask on ch5 with delay 4
    do_reset();
    set_dly(5, 4);
    for (int i = 0; i < 6; i++) send_frame(all_ch(1));
    wait_idle();
    chk("t4_last", bus.out_data, 16);

    // 5: maximum delay and pointer wrap
    do_reset();
    set_dly(0, 31);
    for (int k = 0; k < 40; k++) begin
      f = '0; f[W-1:0] = W'(k);
      send_frame(f);
    end
    wait_idle();
    chk("t5_last", bus.out_data, 39 - 31);

    // 6: dropped frame then reset mid-accumulation
    do_reset();
    send_frame(all_ch(100));
    wait_idle();
    send_frame(all_ch(7));
    a = cyc - 1;
    while (cyc < a + 5) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = all_ch(999);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t6_overrun", bus.overrun, 1);
    chk("t6_in_ready_busy", bus.in_ready, 0);
    while (cyc < a + 8) begin @(posedge clk); #1; end
    chk("t6_held", bus.out_data, 1600);
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_out_data", bus.out_data, 0);
    chk("t6_rst_overrun", bus.overrun, 0);
    repeat (30) @(posedge clk);
    #1;

    // Random: random data, delays (incl. same-cycle writes), busy-time drops
    do_reset();
    for (int i = 0; i < 70; i++) begin
      for (int k = 0; k < N_CH; k++) f[k*W +: W] = W'($urandom);
      send_frame(f, ($urandom_range(0, 3) == 0), $urandom_range(0, N_CH-1),
                 $urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 3) == 0) set_dly($urandom_range(0, N_CH-1), $urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 7) == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = all_ch(-1);
        ovr_m = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    chk("rand_overrun", bus.overrun, longint'(ovr_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
